// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM states,
// default operand width and the bit-counter width helper.
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/fa.sv
// Single-bit full adder cell, the only arithmetic element of the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell sequenced LSB first over WIDTH cycles.
// Optional subtract mode and sub port are enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-2:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             sub_w;
  logic             fa_s;
  logic             fa_co;

`ifdef SERIAL_ADD_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  fa u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Partial result grows from the MSB side; on the last bit res_d is the full sum.
  assign res_d = {fa_s, res_q};

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would let later statements see updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
            a_q     <= a;
            b_q     <= sub_w ? ~b : b;
            carry_q <= sub_w;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          res_q   <= res_d[WIDTH-1:1];
          carry_q <= fa_co;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST_BIT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= fa_co;
            // carry_q is the carry into the MSB during the last bit.
            ovf_q   <= carry_q ^ fa_co;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=16): directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_serial_add_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s,
                                output logic [W-1:0] r, output logic co, output logic ov);
    longint ua, ub, sa, sb, sr, ur;
    ua = longint'(av);
    ub = longint'(bv);
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    if (s) begin
      ur = ua - ub;
      co = (ua >= ub);
      sr = sa - sb;
    end else begin
      ur = ua + ub;
      co = (ur >= (longint'(1) << W));
      sr = sa + sb;
    end
    r  = W'(ur);
    ov = (sr > ((longint'(1) << (W - 1)) - 1)) || (sr < -(longint'(1) << (W - 1)));
  endfunction

  task automatic set_ops(input logic [W-1:0] av, input logic [W-1:0] bv, input logic s);
    a = av;
    b = bv;
`ifdef SERIAL_ADD_SUB_EN
    sub = s;
`else
    if (s) $display("note: subtract requested in add-only build");
`endif
  endtask

  // One operation from the current (post-edge) time; cycle 1 ends on the start edge.
  // inj>0 raises start with other operands at that cycle while the block is busy.
  task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic s, input int inj);
    logic [W-1:0] er;
    logic ec, eo;
    int busy_n, done_n, done_at;
    model(av, bv, s, er, ec, eo);
    set_ops(av, bv, s);
    start = 1'b1;
    busy_n = 0; done_n = 0; done_at = 0;
    for (int cyc = 1; cyc <= W + 3; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      if (inj != 0 && cyc == inj) begin
        set_ops(~av, av ^ bv ^ W'(16'h5a5a), ~s);
        start = 1'b1;
      end
      if (inj != 0 && cyc == inj + 1) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = cyc;
        check({tag, "_sum"}, 64'(sum), 64'(er));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf), 64'(eo));
      end
    end
    check({tag, "_done_cnt"}, 64'(done_n), 64'd1);
    check({tag, "_done_cyc"}, 64'(done_at), 64'(W + 1));
    check({tag, "_busy_cyc"}, 64'(busy_n), 64'(W));
    check({tag, "_sum_hold"}, 64'(sum), 64'(er));
  endtask

  task automatic back_to_back(input logic [W-1:0] a1, input logic [W-1:0] b1,
                              input logic [W-1:0] a2, input logic [W-1:0] b2);
    logic [W-1:0] r1, r2;
    logic c1, o1, c2, o2;
    int done_n;
    model(a1, b1, 1'b0, r1, c1, o1);
    model(a2, b2, 1'b0, r2, c2, o2);
    set_ops(a1, b1, 1'b0);
    start = 1'b1;
    done_n = 0;
    for (int cyc = 1; cyc <= 2 * W + 4; cyc++) begin
      @(posedge clk); #1;
      if (cyc == W)     check("b2b_busy_before", 64'(busy), 64'd1);
      if (cyc == W + 1) begin
        check("b2b_busy_gap", 64'(busy), 64'd0);
        set_ops(a2, b2, 1'b0);
      end
      if (cyc == W + 2) begin
        check("b2b_busy_again", 64'(busy), 64'd1);
        check("b2b_sum_held", 64'(sum), 64'(r1));
        start = 1'b0;
      end
      if (done) begin
        done_n++;
        if (done_n == 1) begin
          check("b2b_done1_cyc", 64'(cyc), 64'(W + 1));
          check("b2b_sum1", 64'(sum), 64'(r1));
          check("b2b_cout1", 64'(cout), 64'(c1));
        end else begin
          check("b2b_done2_cyc", 64'(cyc), 64'(2 * W + 2));
          check("b2b_sum2", 64'(sum), 64'(r2));
          check("b2b_cout2", 64'(cout), 64'(c2));
          check("b2b_ovf2", 64'(ovf), 64'(o2));
        end
      end
    end
    check("b2b_done_cnt", 64'(done_n), 64'd2);
  endtask

  task automatic reset_mid_run();
    int done_n;
    done_n = 0;
    set_ops(W'(16'h0F0F), W'(16'h1111), 1'b0);
    start = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) start = 1'b0;
      if (done) done_n++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_no_done_before", 64'(done_n), 64'd0);
    rst = 1'b0;
    do_op("post_rst", W'(16'h1234), W'(16'h1111), 1'b0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rb;
    logic rs;
    rst = 1'b1;
    start = 1'b0;
    set_ops('0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
    check("reset_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;

    do_op("add_wrap", W'(16'hFFFF), W'(16'h0001), 1'b0, 0);
    do_op("add_ovf", W'(16'h7FFF), W'(16'h0001), 1'b0, 0);
`ifdef SERIAL_ADD_SUB_EN
    do_op("sub_neg", W'(16'h0005), W'(16'h0007), 1'b1, 0);
    do_op("sub_ovf", W'(16'h8000), W'(16'h0001), 1'b1, 0);
`endif
    do_op("ignore_start", W'(16'h1357), W'(16'h2468), 1'b0, 5);
    do_op("add_ovf_again", W'(16'h7FFF), W'(16'h0001), 1'b0, 0);
    reset_mid_run();
    back_to_back(W'(16'hA5A5), W'(16'h5A5B), W'(16'h8000), W'(16'h8000));

    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      do_op($sformatf("rand%0d", i), ra, rb, rs, (i % 4 == 0) ? int'($urandom_range(2, W - 1)) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
